// File: rtl/data_stack.sv
// rtl/data_stack.sv - two-register (TOS/NOS) data stack with register-array spill RAM
// Depth tracking with sticky overflow/underflow; illegal ops leave the stack untouched.
module data_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64,
  localparam int DW   = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top_of_stack,
  output logic [WIDTH-1:0] second_of_stack,
  output logic [DW-1:0]    depth,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int RAM_N = DEPTH - 2;
  localparam int AW    = (RAM_N > 1) ? $clog2(RAM_N) : 1;
  localparam logic [DW-1:0] D_MAX = DW'(DEPTH);
  localparam logic [DW-1:0] D0 = DW'(0);
  localparam logic [DW-1:0] D1 = DW'(1);
  localparam logic [DW-1:0] D2 = DW'(2);
  localparam logic [DW-1:0] D3 = DW'(3);

  typedef enum logic [2:0] {
    OP_NOP     = 3'b000,
    OP_PUSH    = 3'b001,
    OP_DROP    = 3'b010,
    OP_DUP     = 3'b011,
    OP_OVER    = 3'b100,
    OP_SWAP    = 3'b101,
    OP_BINOP   = 3'b110,
    OP_REPLACE = 3'b111
  } op_e;

  op_e              op_w;
  logic [WIDTH-1:0] tos_q, tos_d, nos_q, nos_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic             wr_en;
  logic [WIDTH-1:0] push_val, ram_rd;
  logic [AW-1:0]    wr_addr, rd_addr;
  logic [WIDTH-1:0] ram [RAM_N];

  assign op_w    = op_e'(op);
  assign wr_addr = AW'(depth_q - D2);
  assign rd_addr = AW'(depth_q - D3);
  // Entry below NOS; vacated slots must read as zero, so gate on depth.
  assign ram_rd  = (depth_q >= D3) ? ram[rd_addr] : '0;

  always_comb begin
    tos_d    = tos_q;
    nos_d    = nos_q;
    depth_d  = depth_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    wr_en    = 1'b0;
    push_val = din;
    case (op_w)
      OP_DUP:  push_val = tos_q;
      OP_OVER: push_val = nos_q;
      default: push_val = din;
    endcase
    case (op_w)
      OP_PUSH, OP_DUP, OP_OVER: begin
        if ((op_w == OP_DUP && depth_q == D0) || (op_w == OP_OVER && depth_q < D2)) begin
          udf_d = 1'b1;
        end else if (depth_q == D_MAX) begin
          ovf_d = 1'b1;
        end else begin
          tos_d   = push_val;
          nos_d   = tos_q;
          wr_en   = (depth_q >= D2);
          depth_d = depth_q + D1;
        end
      end
      OP_DROP: begin
        if (depth_q == D0) begin
          udf_d = 1'b1;
        end else begin
          tos_d   = nos_q;
          nos_d   = ram_rd;
          depth_d = depth_q - D1;
        end
      end
      OP_SWAP: begin
        if (depth_q < D2) begin
          udf_d = 1'b1;
        end else begin
          tos_d = nos_q;
          nos_d = tos_q;
        end
      end
      OP_BINOP: begin
        if (depth_q < D2) begin
          udf_d = 1'b1;
        end else begin
          tos_d   = din;
          nos_d   = ram_rd;
          depth_d = depth_q - D1;
        end
      end
      OP_REPLACE: begin
        if (depth_q == D0) udf_d = 1'b1;
        else tos_d = din;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      tos_q   <= '0;
      nos_q   <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      tos_q   <= tos_d;
      nos_q   <= nos_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset && wr_en) ram[wr_addr] <= nos_q;
  end

  assign top_of_stack    = tos_q;
  assign second_of_stack = nos_q;
  assign depth           = depth_q;
  assign empty           = (depth_q == D0);
  assign full            = (depth_q == D_MAX);
  assign overflow        = ovf_q;
  assign underflow       = udf_q;

endmodule

// File: tb/tb_data_stack.sv
// tb/tb_data_stack.sv - table-driven and sequence checks for data_stack
module tb_data_stack;
  localparam int WIDTH = 16;
  localparam int DEPTH = 64;
  localparam int DW    = $clog2(DEPTH + 1);

  localparam logic [2:0] NOP = 3'b000, PUSH = 3'b001, DROP = 3'b010, DUP = 3'b011;
  localparam logic [2:0] OVER = 3'b100, SWAP = 3'b101, BINOP = 3'b110, REPL = 3'b111;

  logic             CLK = 1'b0;
  logic             reset;
  logic [2:0]       op;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] top_of_stack, second_of_stack;
  logic [DW-1:0]    depth;
  logic             empty, full, overflow, underflow;

  int checks   = 0;
  int failures = 0;

  data_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .reset(reset), .op(op), .din(din),
    .top_of_stack(top_of_stack), .second_of_stack(second_of_stack),
    .depth(depth), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst_n;
    logic [2:0] op;
    logic [15:0] din;
    logic [15:0] tos;
    logic [15:0] nos;
    int         dep;
    logic       ovf;
    logic       udf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [2:0] o, input logic [15:0] d,
                     input logic [15:0] t, input logic [15:0] n, input int dp,
                     input logic ov, input logic ud);
    vec_t v;
    v.rst_n = r; v.op = o; v.din = d; v.tos = t; v.nos = n; v.dep = dp; v.ovf = ov; v.udf = ud;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%0d expected=%0d", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [2:0] o, input logic [15:0] d);
    reset = r; op = o; din = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic check_all(input int idx, input logic [15:0] t, input logic [15:0] n,
                           input int dp, input logic ov, input logic ud);
    chk("tos", idx, int'(top_of_stack), int'(t));
    chk("nos", idx, int'(second_of_stack), int'(n));
    chk("depth", idx, int'(depth), dp);
    chk("empty", idx, int'(empty), int'(dp == 0));
    chk("full", idx, int'(full), int'(dp == DEPTH));
    chk("overflow", idx, int'(overflow), int'(ov));
    chk("underflow", idx, int'(underflow), int'(ud));
  endtask

  initial begin
    reset = 1'b0; op = NOP; din = '0;
    // rst, op, din, tos, nos, depth, ovf, udf
    add(0, NOP,   0,      0,      0, 0, 0, 0);
    add(1, PUSH,  1,      1,      0, 1, 0, 0);
    add(1, PUSH,  2,      2,      1, 2, 0, 0);
    add(1, PUSH,  3,      3,      2, 3, 0, 0);
    add(1, BINOP, 5,      5,      1, 2, 0, 0);
    add(1, DROP,  0,      1,      0, 1, 0, 0);
    add(0, NOP,   0,      0,      0, 0, 0, 0);
    add(1, PUSH,  1,      1,      0, 1, 0, 0);
    add(1, PUSH,  2,      2,      1, 2, 0, 0);
    add(1, OVER,  77,     1,      2, 3, 0, 0);
    add(1, DUP,   77,     1,      1, 4, 0, 0);
    add(1, SWAP,  0,      1,      1, 4, 0, 0);
    add(1, DROP,  0,      1,      2, 3, 0, 0);
    add(1, DROP,  0,      2,      1, 2, 0, 0);
    add(1, REPL,  16'hABCD, 16'hABCD, 1, 2, 0, 0);
    add(1, NOP,   16'h1111, 16'hABCD, 1, 2, 0, 0);
    add(1, SWAP,  0,      1, 16'hABCD, 2, 0, 0);
    add(1, BINOP, 16'hFFFF, 16'hFFFF, 0, 1, 0, 0);
    add(1, DROP,  0,      0,      0, 0, 0, 0);
    add(0, NOP,   0,      0,      0, 0, 0, 0);
    add(1, DROP,  0,      0,      0, 0, 0, 1);
    add(1, PUSH,  7,      7,      0, 1, 0, 1);
    add(1, SWAP,  0,      7,      0, 1, 0, 1);
    add(1, BINOP, 9,      7,      0, 1, 0, 1);
    add(1, OVER,  9,      7,      0, 1, 0, 1);
    add(1, DUP,   9,      7,      7, 2, 0, 1);
    add(0, NOP,   0,      0,      0, 0, 0, 0);
    add(1, REPL,  5,      0,      0, 0, 0, 1);
    add(0, NOP,   0,      0,      0, 0, 0, 0);
    add(1, DUP,   5,      0,      0, 0, 0, 1);
    add(0, NOP,   0,      0,      0, 0, 0, 0);
    add(1, PUSH,  4,      4,      0, 1, 0, 0);
    add(1, PUSH,  5,      5,      4, 2, 0, 0);
    add(1, PUSH,  6,      6,      5, 3, 0, 0);
    add(0, PUSH,  9,      0,      0, 0, 0, 0);
    add(1, PUSH,  3,      3,      0, 1, 0, 0);

    step(0, NOP, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst_n, vecs[i].op, vecs[i].din);
      check_all(i, vecs[i].tos, vecs[i].nos, vecs[i].dep, vecs[i].ovf, vecs[i].udf);
    end

    // Fill to DEPTH, overflow attempts, then unwind checking LIFO order
    step(0, NOP, 0);
    for (int k = 1; k <= DEPTH; k++) begin
      step(1, PUSH, 16'(k));
      check_all(1000 + k, 16'(k), 16'(k - 1), k, 0, 0);
    end
    step(1, PUSH, 99);
    check_all(2000, 16'(DEPTH), 16'(DEPTH - 1), DEPTH, 1, 0);
    step(1, DUP, 0);
    check_all(2001, 16'(DEPTH), 16'(DEPTH - 1), DEPTH, 1, 0);
    step(1, OVER, 0);
    check_all(2002, 16'(DEPTH), 16'(DEPTH - 1), DEPTH, 1, 0);
    for (int j = 1; j <= DEPTH - 1; j++) begin
      step(1, DROP, 0);
      check_all(3000 + j, 16'(DEPTH - j), 16'(DEPTH - 1 - j), DEPTH - j, 1, 0);
    end
    step(1, DROP, 0);
    check_all(4000, 0, 0, 0, 1, 0);
    step(1, PUSH, 16'h1234);
    check_all(4001, 16'h1234, 0, 1, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
